shared_mem_scheduler: RTL and testbench

- Transaction scheduler that shares the single data_memory RAM between the two MIPS32 cores.
- Replaces fixed-priority muxing with round-robin arbitration and a registered request capture.
- Runs one RAM transaction at a time: IDLE -> ACCESS -> WAIT -> DONE.
- Returns per-core ack and read data; sits between core MemRequest/MemGrant ports and the RAM.

---
 rtl/shared_mem_scheduler.sv | 166 ++++++++++++++++
 tb/tb_shared_mem_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_mem_scheduler.sv
// Round-robin scheduler sharing one data RAM between two cores; optional owner bus-lock under ARB_LOCK_EN.
// Latency from the sampling IDLE cycle: write ack at +2, read ack at +READ_LAT+2; one transaction in flight.
// Backpressure: each core holds req until its one-cycle ack; the losing core simply stays pending.
module shared_mem_scheduler #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int READ_LAT = 1,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c0_req,
    input  logic          c0_we,
    input  logic          c0_lock,
    input  logic [AW-1:0] c0_addr,
    input  logic [DW-1:0] c0_wdata,
    output logic          c0_grant,
    output logic          c0_ack,
    output logic [DW-1:0] c0_rdata,
    input  logic          c1_req,
    input  logic          c1_we,
    input  logic          c1_lock,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_grant,
    output logic          c1_ack,
    output logic [DW-1:0] c1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy,
    output logic          owner
);

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $error("shared_mem_scheduler: READ_LAT must be in 1..4");
    end
    if (LOCK_MAX < 1) begin : g_bad_lock_max
        $error("shared_mem_scheduler: LOCK_MAX must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_owner;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_c0_rdata;
    logic [DW-1:0]   r_c1_rdata;
    logic [1:0]      r_wait_cnt;
    logic            w_wait_last;
    logic            w_grant_vld;
    logic            w_winner;

`ifdef ARB_LOCK_EN
    localparam int LCW = $clog2(LOCK_MAX + 1);

    logic [LCW-1:0]  r_lock_cnt;
    logic            r_lock_act;
    logic [LCW-1:0]  w_lock_inc;
    logic            w_own_lock;
    logic            w_own_req;

    assign w_own_lock = r_owner ? c1_lock : c0_lock;
    assign w_own_req  = r_owner ? c1_req  : c0_req;
    assign w_lock_inc = r_lock_cnt + LCW'(1);

    // A lock survives into the next arbitration only while under LOCK_MAX; reaching it forces one round-robin pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock_cnt <= '0;
            r_lock_act <= 1'b0;
        end else if (r_state == S_DONE) begin
            if (w_own_lock && (w_lock_inc < LCW'(LOCK_MAX))) begin
                r_lock_act <= 1'b1;
                r_lock_cnt <= w_lock_inc;
            end else begin
                r_lock_act <= 1'b0;
                r_lock_cnt <= '0;
            end
        end else if (r_state == S_IDLE && r_lock_act && !w_own_req) begin
            r_lock_act <= 1'b0;
            r_lock_cnt <= '0;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = c0_lock ^ c1_lock;
`endif

    always_comb begin
        w_grant_vld = c0_req | c1_req;
        w_winner    = (c0_req && c1_req) ? ~r_owner : c1_req;
`ifdef ARB_LOCK_EN
        if (r_lock_act && w_own_req) begin
            w_winner = r_owner;
        end
`endif
    end

    assign w_wait_last = (r_wait_cnt == 2'(READ_LAT - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_vld) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = r_we ? S_DONE : S_WAIT;
            S_WAIT:   if (w_wait_last) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wait_cnt <= '0;
            r_c0_rdata <= '0;
            r_c1_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    r_wait_cnt <= '0;
                    if (w_grant_vld) begin
                        r_owner <= w_winner;
                        r_we    <= w_winner ? c1_we    : c0_we;
                        r_addr  <= w_winner ? c1_addr  : c0_addr;
                        r_wdata <= w_winner ? c1_wdata : c0_wdata;
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 2'd1;
                    if (w_wait_last) begin
                        if (r_owner) r_c1_rdata <= ram_rdata;
                        else         r_c0_rdata <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // All strobes decode straight from registers so an async reset drops them immediately.
    assign busy      = (r_state != S_IDLE);
    assign owner     = r_owner;
    assign c0_grant  = busy && !r_owner;
    assign c1_grant  = busy && r_owner;
    assign c0_ack    = (r_state == S_DONE) && !r_owner;
    assign c1_ack    = (r_state == S_DONE) && r_owner;
    assign ram_we    = (r_state == S_ACCESS) && r_we;
    assign ram_re    = (r_state == S_ACCESS) && !r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign c0_rdata  = r_c0_rdata;
    assign c1_rdata  = r_c1_rdata;

endmodule

// File: tb/tb_shared_mem_scheduler.sv
// Bench for shared_mem_scheduler: directed table, corner sequences, randomized run against a transaction model.
module tb_shared_mem_scheduler;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int READ_LAT = 2;
    localparam int LOCK_MAX = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          c0_req = 1'b0, c0_we = 1'b0, c0_lock = 1'b0;
    logic [31:0]   c0_addr = '0, c0_wdata = '0;
    logic          c1_req = 1'b0, c1_we = 1'b0, c1_lock = 1'b0;
    logic [31:0]   c1_addr = '0, c1_wdata = '0;
    logic          c0_grant, c0_ack, c1_grant, c1_ack;
    logic [31:0]   c0_rdata, c1_rdata;
    logic [31:0]   ram_addr, ram_wdata, ram_rdata;
    logic          ram_we, ram_re, busy, owner;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shared_mem_scheduler #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT), .LOCK_MAX(LOCK_MAX)) u_dut (
        .clk(clk), .rst(rst),
        .c0_req(c0_req), .c0_we(c0_we), .c0_lock(c0_lock), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_grant(c0_grant), .c0_ack(c0_ack), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_lock(c1_lock), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_grant(c1_grant), .c1_ack(c1_ack), .c1_rdata(c1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 8) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
    endfunction

    // RAM environment: read data appears the cycle after the strobe and stays until the next read.
    logic [31:0] ram_mem [64];
    logic [5:0]  rd_idx = '0;
    bit          mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (ram_we) begin
            ram_mem[ram_addr[7:2]] <= ram_wdata;
        end
        if (ram_re) rd_idx <= ram_addr[7:2];
    end
    assign ram_rdata = ram_mem[rd_idx];

    typedef struct {
        bit          core;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] m_mem [64];
    logic [31:0] exp_rd [2];
    int          order [6];
    int          exp_order [6];
    bit          q_req [2], q_we [2];
    logic [31:0] q_addr [2], q_wdata [2];
    bit          cap_core, cap_we, m_owner, win;
    logic [31:0] cap_addr, cap_wdata, pend_rd;
    int          t_start, t_ack, free_at;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] ctl();
        return {c0_grant, c1_grant, c0_ack, c1_ack, ram_we, ram_re, busy, owner};
    endfunction

    task automatic drive(input int core, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (core == 0) begin
            c0_req = req; c0_we = we; c0_addr = addr; c0_wdata = wdata;
        end else begin
            c1_req = req; c1_we = we; c1_addr = addr; c1_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        c0_lock = 1'b0;
        c1_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Issues one request from an IDLE cycle (t0); scrambles the inputs once captured.
    task automatic do_txn(input bit core, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output int strobes, output bit ok);
        drive(int'(core), 1'b1, we, addr, wdata);
        lat = -1; strobes = 0; ok = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (c0_grant && c1_grant) ok = 1'b0;
            if ((core ? c0_ack : c1_ack)) ok = 1'b0;
            if (ram_we || ram_re) begin
                strobes++;
                if (k != 1 || ram_we !== we || ram_addr !== addr || (we && ram_wdata !== wdata)) ok = 1'b0;
            end
            if (k == 1) begin
                if (!(core ? c1_grant : c0_grant)) ok = 1'b0;
                drive(int'(core), 1'b0, ~we, $urandom, $urandom);
            end
            if ((core ? c1_ack : c0_ack)) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d mismatched so far", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, strobes, seen, n;
        bit ok;
        logic [7:0] exp_ctl;
        bit in_acc, in_busy, is_ack;

        for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);

        // Reset values, then async reset in the middle of an ACCESS cycle with c0_req held.
        repeat (2) @(negedge clk);
        chk("reset_ctl", ctl(), 8'h01);
        rst = 1'b1;
        drive(0, 1, 1, 32'h3C, 32'h1111_2222);
        @(negedge clk);
        chk("write_access", ctl(), 8'b1000_1010);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_ctl", ctl(), 8'h01);
        chk("async_reset_bus", {ram_addr, ram_wdata}, 64'h0);
        chk("async_reset_rdata", {c0_rdata, c1_rdata}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("release_grant", ctl(), 8'b1000_0110);
        drive(0, 0, 0, 32'h0, 32'h0);
        lat = -1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (c0_ack) begin lat = k; break; end
        end
        chk("first_read_ack", lat, READ_LAT + 1);
        chk("first_read_rdata", {c0_rdata, c1_rdata}, {init_word(0), 32'h0});
        exp_rd[0] = init_word(0);
        exp_rd[1] = 32'h0;
        @(negedge clk);

        tbl[0] = '{1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0,         2};
        tbl[1] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, READ_LAT + 2};
        tbl[2] = '{1'b1, 1'b0, 32'h20, 32'h0,         32'h1234_5678, READ_LAT + 2};
        tbl[3] = '{1'b0, 1'b1, 32'h24, 32'hCAFE_F00D, 32'h0,         2};
        tbl[4] = '{1'b0, 1'b0, 32'h24, 32'h0,         32'hCAFE_F00D, READ_LAT + 2};
        tbl[5] = '{1'b1, 1'b1, 32'h20, 32'h0BAD_F00D, 32'h0,         2};
        tbl[6] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'h0BAD_F00D, READ_LAT + 2};
        tbl[7] = '{1'b1, 1'b0, 32'h04, 32'h0,         32'hA500_0001, READ_LAT + 2};
        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i].core, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, strobes, ok);
            if (tbl[i].we) m_mem[tbl[i].addr[7:2]] = tbl[i].wdata;
            else           exp_rd[tbl[i].core] = tbl[i].exp_rdata;
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d_strobe", i), {strobes, 31'h0, ok}, {32'd1, 31'h0, 1'b1});
            chk($sformatf("tbl%0d_own_rdata", i), tbl[i].core ? c1_rdata : c0_rdata, exp_rd[tbl[i].core]);
            chk($sformatf("tbl%0d_other_rdata", i), tbl[i].core ? c0_rdata : c1_rdata, exp_rd[!tbl[i].core]);
            @(negedge clk);
        end

        // Reset while core1 is in WAIT: transaction abandoned, then core0 reads normally.
        drive(1, 1, 0, 32'h20, 32'h0);
        @(negedge clk);
        drive(1, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("midread_wait", ctl(), 8'b0100_0011);
        rst = 1'b0;
        #1;
        chk("midread_reset_ctl", ctl(), 8'h01);
        chk("midread_reset_rdata", {c0_rdata, c1_rdata}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (c0_ack || c1_ack || busy || ram_re || ram_we) seen++;
        end
        chk("midread_quiet", seen, 0);
        do_txn(1'b0, 1'b0, 32'h20, 32'h0, lat, strobes, ok);
        chk("midread_next_latency", lat, READ_LAT + 2);
        chk("midread_next_rdata", {c0_rdata, c1_rdata}, {m_mem[8], 32'h0});

        // Contention: both held, core0 asking for lock.
`ifdef ARB_LOCK_EN
        exp_order = '{0, 0, 1, 0, 0, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        do_reset();
        c0_lock = 1'b1;
        drive(0, 1, 1, 32'h30, 32'h0000_0A0A);
        drive(1, 1, 1, 32'h34, 32'h0000_0B0B);
        for (int i = 0; i < 6; i++) order[i] = -1;
        n = 0; seen = 0;
        for (int k = 0; k < 200 && n < 6; k++) begin
            @(negedge clk);
            if (c0_grant && c1_grant) seen++;
            if (c0_ack && n < 6) begin order[n] = 0; n++; end
            if (c1_ack && n < 6) begin order[n] = 1; n++; end
        end
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        c0_lock = 1'b0;
        m_mem[12] = 32'h0000_0A0A;
        m_mem[13] = 32'h0000_0B0B;
        for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
        chk("rr_both_grants", seen, 0);

        // Randomized run: transaction-level model predicts every cycle's outputs.
        do_reset();
        exp_rd[0] = '0; exp_rd[1] = '0;
        m_owner = 1'b1; cap_core = 1'b0; cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; pend_rd = '0;
        t_start = -100; t_ack = -100; free_at = 0;
        for (int k = 0; k < 2; k++) begin
            q_req[k] = 1'b0; q_we[k] = 1'b0; q_addr[k] = '0; q_wdata[k] = '0;
        end
        for (int c = 0; c < 1200; c++) begin
            if (c > 0) @(negedge clk);
            in_acc  = (c == t_start + 1);
            in_busy = (c > t_start) && (c <= t_ack);
            is_ack  = (c == t_ack);
            if (is_ack && !cap_we) exp_rd[cap_core] = pend_rd;
            exp_ctl = {in_busy && !cap_core, in_busy && cap_core, is_ack && !cap_core, is_ack && cap_core,
                       in_acc && cap_we, in_acc && !cap_we, in_busy, m_owner};
            chk("rnd_ctl", ctl(), exp_ctl);
            chk("rnd_rdata", {c0_rdata, c1_rdata}, {exp_rd[0], exp_rd[1]});
            if (in_acc) chk("rnd_ram_bus", {ram_addr, cap_we ? ram_wdata : 32'h0}, {cap_addr, cap_we ? cap_wdata : 32'h0});
            for (int k = 0; k < 2; k++) begin
                if (!q_req[k] && !(c < t_ack && cap_core == 1'(k)) && $urandom_range(0, 2) == 0) begin
                    q_req[k]   = 1'b1;
                    q_we[k]    = 1'($urandom_range(0, 1));
                    q_addr[k]  = 32'($urandom_range(0, 15)) << 2;
                    q_wdata[k] = $urandom;
                end
            end
            if (c >= free_at && (q_req[0] || q_req[1])) begin
                win       = (q_req[0] && q_req[1]) ? !m_owner : q_req[1];
                cap_core  = win;
                cap_we    = q_we[win];
                cap_addr  = q_addr[win];
                cap_wdata = q_wdata[win];
                if (cap_we) m_mem[cap_addr[7:2]] = cap_wdata;
                else        pend_rd = m_mem[cap_addr[7:2]];
                t_start   = c;
                t_ack     = c + (cap_we ? 2 : READ_LAT + 2);
                free_at   = t_ack + 1;
                m_owner   = win;
                q_req[win] = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (t_start == c && cap_core == 1'(k))
                    drive(k, 1'b1, cap_we, cap_addr, cap_wdata);
                else if (c < t_ack && cap_core == 1'(k))
                    drive(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
                else
                    drive(k, q_req[k], q_we[k], q_addr[k], q_wdata[k]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
